// File: rtl/ibex_cheri_memchecker_mo.sv
// CHERI memory access checker with support for several outstanding requests.
// Every granted request is checked against the authorising capability. Its
// exception vector is queued and handed back together with the matching
// rvalid. Capability accesses take two bus beats, and both beats report the
// result of a single bounds check made at the first beat.
`timescale 1ns/1ps
module ibex_cheri_memchecker_mo #(
  parameter bit          DataMem        = 1'b1,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned PermWidth      = 31,
  parameter int unsigned PermLoadIdx    = 2,
  parameter int unsigned PermStoreIdx   = 3,
  parameter int unsigned PermExecIdx    = 1,
  parameter int unsigned CapBytes       = 8,
  parameter bit          StableOut      = 1'b1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  auth_tag_i,
  input  logic                                  auth_sealed_i,
  input  logic [AddrWidth-1:0]                  auth_base_i,
  input  logic [AddrWidth:0]                    auth_top_i,
  input  logic [PermWidth-1:0]                  auth_perms_i,
  input  logic                                  data_req_i,
  input  logic                                  data_gnt_i,
  input  logic                                  data_rvalid_i,
  input  logic [AddrWidth-1:0]                  data_addr_i,
  input  logic                                  data_we_i,
  input  logic [1:0]                            data_type_i,
  input  logic [3:0]                            data_be_i,
  input  logic                                  data_cap_i,
  output logic                                  data_req_o,
  output logic                                  data_we_o,
  output logic [5:0]                            cheri_mem_exc_o,
  output logic                                  instr_upper_exc_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  spurious_rvalid_o
);

  // state | meaning
  // IDLE  | every granted beat pushes a freshly computed exception vector
  // CAP2  | first capability beat granted; next granted beat pushes the
  //       | vector latched at the first beat

  localparam int unsigned OutW   = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned ExtW   = AddrWidth + 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  localparam logic [OutW-1:0] FullCnt = OutW'(MaxOutstanding);

  typedef enum logic {
    IDLE = 1'b0,
    CAP2 = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Entry layout: {upper, LENGTH, EXEC, STORE, LOAD, SEAL, TAG}
  logic [6:0]           fifo_q [MaxOutstanding];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OutW-1:0]      count_q;
  logic [6:0]           cap_vec_q;
  logic [6:0]           last_q;

  logic [1:0]           byte_off;
  logic [AddrWidth-1:0] eff_addr;
  logic [ExtW-1:0]      acc_size;
  logic [ExtW-1:0]      acc_end;
  logic [ExtW-1:0]      up_end;
  logic                 len_viol;
  logic                 upper_d;
  logic [5:0]           exc_d;
  logic [6:0]           fresh_vec;
  logic [6:0]           push_vec;
  logic [6:0]           head_vec;
  logic [6:0]           hold_vec;
  logic                 full, empty, push, pop;

  // The low address bits are ignored by design: requests are word aligned.
  logic unused_inputs;
  assign unused_inputs = ^{data_addr_i[1:0], auth_perms_i};

  // ---------------------------------------------------------------------
  // Access check
  // ---------------------------------------------------------------------

  // Byte offset taken from the lowest enabled byte lane (data port only).
  always_comb begin
    byte_off = 2'b00;
    if (DataMem) begin
      if (data_be_i[0])      byte_off = 2'd0;
      else if (data_be_i[1]) byte_off = 2'd1;
      else if (data_be_i[2]) byte_off = 2'd2;
      else if (data_be_i[3]) byte_off = 2'd3;
    end
  end

  assign eff_addr = {data_addr_i[AddrWidth-1:2], byte_off};

  // Number of bytes the access touches.
  always_comb begin
    acc_size = '0;
    if (!DataMem) begin
      acc_size = ExtW'(2);
    end else if (data_cap_i) begin
      acc_size = ExtW'(CapBytes);
    end else begin
      case (data_type_i)
        2'b00:   acc_size = ExtW'(4);
        2'b01:   acc_size = ExtW'(2);
        2'b10:   acc_size = ExtW'(1);
        default: acc_size = ExtW'(8);
      endcase
    end
  end

  // One extra bit keeps the carry, so an access wrapping the address space
  // ends above any representable top and is flagged.
  assign acc_end  = {1'b0, eff_addr} + acc_size;
  assign len_viol = (eff_addr < auth_base_i) | (acc_end > auth_top_i);

  // Fetches are checked as the lower halfword; the upper halfword at +2 is
  // reported separately so a 32-bit instruction straddling top is caught.
  assign up_end  = {1'b0, eff_addr | AddrWidth'(2)} + ExtW'(2);
  assign upper_d = ~DataMem & (up_end > auth_top_i);

  assign exc_d[0] = ~auth_tag_i;
  assign exc_d[1] = auth_sealed_i;
  assign exc_d[2] = DataMem & ~data_we_i & ~auth_perms_i[PermLoadIdx];
  assign exc_d[3] = DataMem &  data_we_i & ~auth_perms_i[PermStoreIdx];
  assign exc_d[4] = ~DataMem & ~auth_perms_i[PermExecIdx];
  assign exc_d[5] = len_viol;

  assign fresh_vec = {upper_d, exc_d};

  // ---------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);

  // A full queue blocks the request even when a pop frees a slot this cycle,
  // which keeps the request path independent of rvalid.
  assign data_req_o = data_req_i & ~full;
  assign push       = data_req_o & data_gnt_i;
  assign pop        = data_rvalid_i & ~empty;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: track the second beat of a capability access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (push && data_cap_i) state_d = CAP2;
      CAP2: if (push)               state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // FSM outputs: choose which vector is pushed and gates the store.
  always_comb begin
    push_vec = fresh_vec;
    if (state_q == CAP2) begin
      push_vec = cap_vec_q;
    end
    data_we_o = data_we_i & ~|push_vec[5:0];
  end

  // Latch the first-beat result of a capability access for its second beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_vec_q <= '0;
    end else if ((state_q == IDLE) && push && data_cap_i) begin
      cap_vec_q <= fresh_vec;
    end
  end

  // ---------------------------------------------------------------------
  // Exception FIFO
  // ---------------------------------------------------------------------

  // Entry storage, written at the tail on every push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= push_vec;
    end
  end

  // Pointers wrap at the queue depth, which need not be a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Occupancy; a push and pop in the same cycle cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + OutW'(1);
        2'b01:   count_q <= count_q - OutW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Remember the most recently returned vector for the hold-output mode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= '0;
    end else if (pop) begin
      last_q <= head_vec;
    end
  end

  // ---------------------------------------------------------------------
  // Response side
  // ---------------------------------------------------------------------

  assign head_vec = fifo_q[rd_ptr_q];
  assign hold_vec = StableOut ? last_q : 7'd0;

  // The head entry is returned in the same cycle as its rvalid.
  always_comb begin
    cheri_mem_exc_o   = hold_vec[5:0];
    instr_upper_exc_o = hold_vec[6];
    if (pop) begin
      cheri_mem_exc_o   = head_vec[5:0];
      instr_upper_exc_o = head_vec[6];
    end
  end

  assign outstanding_o     = count_q;
  assign spurious_rvalid_o = data_rvalid_i & empty;

endmodule

// File: tb/tb_ibex_cheri_memchecker_mo.sv
// Bench for the multi-outstanding CHERI memory checker. A data-port instance
// (hold outputs) is tracked by a queue-based reference model; an
// instruction-port instance (zeroed outputs) shares the stimulus.
`timescale 1ns/1ps
module tb_ibex_cheri_memchecker_mo;

  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tag, sealed;
  logic [31:0] base;
  logic [32:0] top;
  logic [30:0] perms;
  logic        req, gnt, rvalid;
  logic [31:0] addr;
  logic        we;
  logic [1:0]  dtype;
  logic [3:0]  be;
  logic        cap;

  logic        d_req, d_we, d_up, d_spur;
  logic [5:0]  d_exc;
  logic [1:0]  d_occ;
  logic        i_req, i_we, i_up, i_spur;
  logic [5:0]  i_exc;
  logic [1:0]  i_occ;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ibex_cheri_memchecker_mo #(.DataMem(1'b1), .MaxOutstanding(MO), .StableOut(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .auth_tag_i(tag), .auth_sealed_i(sealed), .auth_base_i(base), .auth_top_i(top),
    .auth_perms_i(perms), .data_req_i(req), .data_gnt_i(gnt), .data_rvalid_i(rvalid),
    .data_addr_i(addr), .data_we_i(we), .data_type_i(dtype), .data_be_i(be),
    .data_cap_i(cap), .data_req_o(d_req), .data_we_o(d_we), .cheri_mem_exc_o(d_exc),
    .instr_upper_exc_o(d_up), .outstanding_o(d_occ), .spurious_rvalid_o(d_spur)
  );

  ibex_cheri_memchecker_mo #(.DataMem(1'b0), .MaxOutstanding(MO), .StableOut(1'b0)) dut_i (
    .clk_i(clk), .rst_ni(rst_n),
    .auth_tag_i(tag), .auth_sealed_i(sealed), .auth_base_i(base), .auth_top_i(top),
    .auth_perms_i(perms), .data_req_i(req), .data_gnt_i(gnt), .data_rvalid_i(rvalid),
    .data_addr_i(addr), .data_we_i(we), .data_type_i(dtype), .data_be_i(be),
    .data_cap_i(cap), .data_req_o(i_req), .data_we_o(i_we), .cheri_mem_exc_o(i_exc),
    .instr_upper_exc_o(i_up), .outstanding_o(i_occ), .spurious_rvalid_o(i_spur)
  );

  // Reference model of the data-port instance.
  logic [6:0] mq[$];
  bit         m_pend;
  logic [6:0] m_capv, m_last, m_pushv;
  bit         m_push, m_pop;
  bit         e_req, e_we, e_spur;
  logic [6:0] e_out;
  int         e_occ;

  // Exception vector {upper, LENGTH, EXEC, STORE, LOAD, SEAL, TAG} from the
  // access rules, using wide integer arithmetic.
  function automatic logic [6:0] ref_vec(bit dm);
    longint ea, sz, lo, hi;
    int off;
    bit len, up;
    off = 0;
    if (dm) begin
      for (int i = 3; i >= 0; i--) if (be[i]) off = i;
    end
    ea = {32'b0, addr[31:2], 2'b00};
    ea = ea + off;
    if (!dm)           sz = 2;
    else if (cap)      sz = 8;
    else if (dtype == 2'd0) sz = 4;
    else if (dtype == 2'd1) sz = 2;
    else if (dtype == 2'd2) sz = 1;
    else               sz = 8;
    lo  = {32'b0, base};
    hi  = {31'b0, top};
    len = (ea < lo) || (ea + sz > hi);
    up  = !dm && (((ea | 2) + 2) > hi);
    return {up, len, !dm && !perms[1], dm && we && !perms[3], dm && !we && !perms[2],
            sealed, !tag};
  endfunction

  function automatic void model_eval();
    logic [6:0] sel;
    sel     = m_pend ? m_capv : ref_vec(1'b1);
    e_req   = req && (mq.size() < MO);
    m_push  = e_req && gnt;
    m_pushv = sel;
    e_we    = we && (sel[5:0] == 6'd0);
    m_pop   = rvalid && (mq.size() > 0);
    e_out   = m_pop ? mq[0] : m_last;
    e_spur  = rvalid && (mq.size() == 0);
    e_occ   = mq.size();
  endfunction

  function automatic void model_commit();
    if (m_pop) m_last = mq.pop_front();
    if (m_push) begin
      mq.push_back(m_pushv);
      if (m_pend) m_pend = 0;
      else if (cap) begin
        m_pend = 1;
        m_capv = m_pushv;
      end
    end
  endfunction

  task automatic drive(input bit r, input bit g, input bit v, input logic [31:0] a,
                       input bit w, input logic [1:0] t, input logic [3:0] b, input bit c);
    @(negedge clk);
    req = r; gnt = g; rvalid = v; addr = a; we = w; dtype = t; be = b; cap = c;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_auth(input bit tg, input bit sl, input logic [31:0] b,
                          input logic [32:0] t, input logic [30:0] p);
    tag = tg; sealed = sl; base = b; top = t; perms = p;
  endtask

  task automatic do_reset();
    req = 0; gnt = 0; rvalid = 0; we = 0; cap = 0; addr = '0; dtype = 2'd0; be = 4'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_pend = 0;
    m_last = '0;
    m_capv = '0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 32'h0, 0, 2'd0, 4'h0, 0);
    total++; if (d_occ !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", d_occ); end
    total++; if (d_exc !== 6'd0) begin bad++; $display("FAIL reset_exc got=%b exp=0", d_exc); end
    total++; if (d_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", d_req); end
    total++; if (d_spur !== 1'b0) begin bad++; $display("FAIL reset_spur got=%b exp=0", d_spur); end
    total++; if ({i_up, i_exc} !== 7'd0) begin bad++; $display("FAIL reset_iexc got=%b exp=0", {i_up, i_exc}); end
    tick();
  endtask

  task automatic test_bounds();
    do_reset();
    set_auth(1, 0, 32'h1000, 33'h1100, 31'h4);
    drive(1, 1, 0, 32'h10FC, 0, 2'd0, 4'hF, 0);
    total++; if (d_req !== 1'b1) begin bad++; $display("FAIL bounds_req got=%b exp=1", d_req); end
    total++; if (d_we !== 1'b0) begin bad++; $display("FAIL bounds_we_a got=%b exp=0", d_we); end
    tick();
    drive(1, 1, 0, 32'h1100, 0, 2'd0, 4'hF, 0);
    total++; if (d_we !== 1'b0) begin bad++; $display("FAIL bounds_we_b got=%b exp=0", d_we); end
    tick();
    drive(0, 0, 1, 32'h0, 0, 2'd0, 4'h0, 0);
    total++; if (d_exc !== 6'b000000) begin bad++; $display("FAIL bounds_exc_a got=%b exp=000000", d_exc); end
    tick();
    drive(0, 0, 1, 32'h0, 0, 2'd0, 4'h0, 0);
    total++; if (d_exc !== 6'b100000) begin bad++; $display("FAIL bounds_exc_b got=%b exp=100000", d_exc); end
    tick();
  endtask

  task automatic test_store();
    do_reset();
    set_auth(1, 0, 32'h2000, 33'h2100, 31'h4);
    drive(1, 1, 0, 32'h2000, 1, 2'd2, 4'b1000, 0);
    total++; if (d_we !== 1'b0) begin bad++; $display("FAIL store_block_we got=%b exp=0", d_we); end
    tick();
    drive(0, 0, 1, 32'h0, 0, 2'd0, 4'h0, 0);
    total++; if (d_exc !== 6'b001000) begin bad++; $display("FAIL store_exc got=%b exp=001000", d_exc); end
    tick();
    set_auth(1, 0, 32'h2000, 33'h2100, 31'hC);
    drive(1, 1, 0, 32'h2000, 1, 2'd2, 4'b1000, 0);
    total++; if (d_we !== 1'b1) begin bad++; $display("FAIL store_allow_we got=%b exp=1", d_we); end
    tick();
    drive(0, 0, 1, 32'h0, 0, 2'd0, 4'h0, 0);
    total++; if (d_exc !== 6'b000000) begin bad++; $display("FAIL store_allow_exc got=%b exp=000000", d_exc); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] a [3];
    a[0] = 32'h1000; a[1] = 32'h1100; a[2] = 32'h1004;
    do_reset();
    set_auth(1, 0, 32'h1000, 33'h1100, 31'h4);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, a[i], 0, 2'd0, 4'hF, 0);
      total++;
      if (d_req !== (i < 2)) begin bad++; $display("FAIL bp_req%0d got=%b exp=%b", i, d_req, i < 2); end
      tick();
    end
    drive(1, 0, 0, 32'h1000, 0, 2'd0, 4'hF, 0);
    total++; if (d_occ !== 2'd2) begin bad++; $display("FAIL bp_occ got=%0d exp=2", d_occ); end
    tick();
    drive(1, 0, 1, 32'h1000, 0, 2'd0, 4'hF, 0);
    total++; if (d_req !== 1'b0) begin bad++; $display("FAIL bp_req_fullpop got=%b exp=0", d_req); end
    total++; if (d_exc !== 6'b000000) begin bad++; $display("FAIL bp_exc_a got=%b exp=000000", d_exc); end
    tick();
    drive(1, 0, 1, 32'h1000, 0, 2'd0, 4'hF, 0);
    total++; if (d_req !== 1'b1) begin bad++; $display("FAIL bp_req_again got=%b exp=1", d_req); end
    total++; if (d_exc !== 6'b100000) begin bad++; $display("FAIL bp_exc_b got=%b exp=100000", d_exc); end
    tick();
    drive(0, 0, 0, 32'h0, 0, 2'd0, 4'h0, 0);
    total++; if (d_occ !== 2'd0) begin bad++; $display("FAIL bp_occ_end got=%0d exp=0", d_occ); end
    tick();
  endtask

  task automatic test_cap();
    do_reset();
    set_auth(1, 0, 32'h1000, 33'h1100, '1);
    drive(1, 1, 0, 32'h10F8, 1, 2'd0, 4'hF, 1);
    total++; if (d_we !== 1'b1) begin bad++; $display("FAIL cap_ok_we1 got=%b exp=1", d_we); end
    tick();
    // Second beat at an address that would fail on its own; the first-beat
    // result must be reused.
    drive(1, 1, 0, 32'h2000, 1, 2'd0, 4'hF, 1);
    total++; if (d_we !== 1'b1) begin bad++; $display("FAIL cap_ok_we2 got=%b exp=1", d_we); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 32'h0, 0, 2'd0, 4'h0, 0);
      total++; if (d_exc !== 6'b000000) begin bad++; $display("FAIL cap_ok_exc%0d got=%b exp=000000", i, d_exc); end
      tick();
    end
    drive(1, 1, 0, 32'h10FC, 1, 2'd0, 4'hF, 1);
    total++; if (d_we !== 1'b0) begin bad++; $display("FAIL cap_bad_we1 got=%b exp=0", d_we); end
    tick();
    drive(1, 1, 0, 32'h1000, 1, 2'd0, 4'hF, 1);
    total++; if (d_we !== 1'b0) begin bad++; $display("FAIL cap_bad_we2 got=%b exp=0", d_we); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 32'h0, 0, 2'd0, 4'h0, 0);
      total++; if (d_exc !== 6'b100000) begin bad++; $display("FAIL cap_bad_exc%0d got=%b exp=100000", i, d_exc); end
      tick();
    end
  endtask

  task automatic test_instr();
    do_reset();
    set_auth(1, 0, 32'h3000, 33'h3002, '1);
    drive(1, 1, 0, 32'h3000, 0, 2'd0, 4'h0, 0);
    tick();
    drive(0, 0, 1, 32'h0, 0, 2'd0, 4'h0, 0);
    total++; if (i_exc !== 6'b000000) begin bad++; $display("FAIL instr_exc got=%b exp=000000", i_exc); end
    total++; if (i_up !== 1'b1) begin bad++; $display("FAIL instr_upper got=%b exp=1", i_up); end
    tick();
    set_auth(1, 0, 32'h3000, 33'h3002, 31'h7FFF_FFFD);
    drive(1, 1, 0, 32'h3000, 0, 2'd0, 4'h0, 0);
    tick();
    drive(0, 0, 1, 32'h0, 0, 2'd0, 4'h0, 0);
    total++; if (i_exc !== 6'b010000) begin bad++; $display("FAIL instr_exec got=%b exp=010000", i_exc); end
    total++; if (i_up !== 1'b1) begin bad++; $display("FAIL instr_upper2 got=%b exp=1", i_up); end
    tick();
    drive(0, 0, 0, 32'h0, 0, 2'd0, 4'h0, 0);
    total++; if ({i_up, i_exc} !== 7'd0) begin bad++; $display("FAIL instr_zero_idle got=%b exp=0", {i_up, i_exc}); end
    total++; if (d_exc !== e_out[5:0]) begin bad++; $display("FAIL data_hold_idle got=%b exp=%b", d_exc, e_out[5:0]); end
    total++; if (d_exc !== 6'b100000) begin bad++; $display("FAIL data_hold_const got=%b exp=100000", d_exc); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    set_auth(1, 0, 32'hFFFF_FF00, 33'h1_0000_0000, '1);
    drive(1, 1, 0, 32'hFFFF_FFF8, 0, 2'd3, 4'hF, 0);
    tick();
    drive(0, 0, 1, 32'h0, 0, 2'd0, 4'h0, 0);
    total++; if (d_exc !== 6'b000000) begin bad++; $display("FAIL wrap_fit got=%b exp=000000", d_exc); end
    tick();
    drive(1, 1, 0, 32'hFFFF_FFFC, 0, 2'd3, 4'hF, 0);
    tick();
    drive(0, 0, 1, 32'h0, 0, 2'd0, 4'h0, 0);
    total++; if (d_exc !== 6'b100000) begin bad++; $display("FAIL wrap_carry got=%b exp=100000", d_exc); end
    tick();
  endtask

  task automatic test_spurious_reset();
    do_reset();
    drive(0, 0, 1, 32'h0, 0, 2'd0, 4'h0, 0);
    total++; if (d_spur !== 1'b1) begin bad++; $display("FAIL spur_pulse got=%b exp=1", d_spur); end
    total++; if (d_occ !== 2'd0) begin bad++; $display("FAIL spur_occ got=%0d exp=0", d_occ); end
    tick();
    drive(0, 0, 0, 32'h0, 0, 2'd0, 4'h0, 0);
    total++; if (d_spur !== 1'b0) begin bad++; $display("FAIL spur_clear got=%b exp=0", d_spur); end
    tick();
    set_auth(1, 0, 32'h1000, 33'h1100, 31'h4);
    drive(1, 1, 0, 32'h2000, 0, 2'd0, 4'hF, 0); tick();
    drive(1, 1, 0, 32'h2000, 0, 2'd0, 4'hF, 0); tick();
    drive(0, 0, 1, 32'h0, 0, 2'd0, 4'h0, 0);    tick();
    drive(1, 1, 0, 32'h2000, 0, 2'd0, 4'hF, 0); tick();
    drive(0, 0, 0, 32'h0, 0, 2'd0, 4'h0, 0);
    total++; if (d_occ !== 2'd2) begin bad++; $display("FAIL rst_pre_occ got=%0d exp=2", d_occ); end
    total++; if (d_exc !== 6'b100000) begin bad++; $display("FAIL rst_pre_exc got=%b exp=100000", d_exc); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (d_occ !== 2'd0) begin bad++; $display("FAIL rst_async_occ got=%0d exp=0", d_occ); end
    total++; if (d_exc !== 6'd0) begin bad++; $display("FAIL rst_async_exc got=%b exp=0", d_exc); end
    total++; if (i_occ !== 2'd0) begin bad++; $display("FAIL rst_async_iocc got=%0d exp=0", i_occ); end
    do_reset();
  endtask

  task automatic test_random();
    logic [31:0] b;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n % 40 == 0) begin
        b = 32'h1000 + 32'(($urandom % 4) * 4);
        set_auth(($urandom % 8) != 0, ($urandom % 8) == 0, b,
                 {1'b0, b} + 33'(16 + ($urandom % 32)), 31'($urandom));
      end
      drive(($urandom % 4) != 0, ($urandom % 5) < 3, ($urandom % 5) < 2,
            (base - 32'd8 + 32'($urandom % 64)) & 32'hFFFF_FFFC,
            $urandom % 2, 2'($urandom), 4'($urandom), ($urandom % 7) == 0);
      total++; if (d_req !== e_req) begin bad++; $display("FAIL rnd_req n=%0d got=%b exp=%b", n, d_req, e_req); end
      total++; if (d_we !== e_we) begin bad++; $display("FAIL rnd_we n=%0d got=%b exp=%b", n, d_we, e_we); end
      total++; if (d_exc !== e_out[5:0]) begin bad++; $display("FAIL rnd_exc n=%0d got=%b exp=%b", n, d_exc, e_out[5:0]); end
      total++; if (d_up !== e_out[6]) begin bad++; $display("FAIL rnd_up n=%0d got=%b exp=%b", n, d_up, e_out[6]); end
      total++; if (d_occ !== 2'(e_occ)) begin bad++; $display("FAIL rnd_occ n=%0d got=%0d exp=%0d", n, d_occ, e_occ); end
      total++; if (d_spur !== e_spur) begin bad++; $display("FAIL rnd_spur n=%0d got=%b exp=%b", n, d_spur, e_spur); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_auth(0, 0, 32'h0, 33'h0, '0);
    test_reset();
    test_bounds();
    test_store();
    test_backpressure();
    test_cap();
    test_instr();
    test_wrap();
    test_spurious_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
